// File: rtl/inst_rom_pkg.sv
// Shared constants and types for the instruction ROM / boot loader.
//   ZERO_WORD : value driven when fetch is disabled
//   NOP_INST  : addi x0,x0,0, returned for any fetch outside the loaded image
//   rom_state_e : loader FSM states
package inst_rom_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } rom_state_e;

endpackage

// File: rtl/rom_byte_packer.sv
// Packs loader bytes little-endian into 32-bit words.
//   clk_i, rst_i : clock, async active-low reset
//   xfer_i       : a byte is accepted this cycle
//   byte_i       : accepted byte
//   last_i       : accepted byte ends the image (forces a partial commit)
//   word_o       : word to write, including the byte being accepted now
//   commit_o     : write word_o to the array on this edge
module rom_byte_packer
    import inst_rom_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        xfer_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        commit_o
);

    logic [1:0]  byte_cnt;
    logic [31:0] staging;

    // Lanes above byte_cnt are always zero in staging (cleared on every
    // commit), so a partial word comes out zero-padded for free.
    always_comb begin
        word_o   = staging | ({24'h0, byte_i} << {byte_cnt, 3'b000});
        commit_o = xfer_i && ((byte_cnt == 2'd3) || last_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            byte_cnt <= 2'd0;
            staging  <= ZERO_WORD;
        end else if (commit_o) begin
            byte_cnt <= 2'd0;
            staging  <= ZERO_WORD;
        end else if (xfer_i) begin
            byte_cnt <= byte_cnt + 2'd1;
            staging  <= word_o;
        end
    end

endmodule

// File: rtl/inst_rom.sv
// Instruction memory with byte-serial boot loader.
//   clk_i, rst_i   : clock, async active-low reset
//   ce_i, addr_i   : fetch enable and byte address from the core
//   data_o         : instruction word, combinational from addr_i
//   ld_valid_i/ld_data_i/ld_last_i/ld_ready_o : loader byte stream
//   boot_done_o    : image loaded, core may leave reset
//   err_o          : sticky, image exceeded DEPTH words
//
// state   | meaning
// ST_LOAD | accepting loader bytes, fetches return NOP
// ST_RUN  | image frozen, fetches served from the array
module inst_rom
    import inst_rom_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] data_o,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_data_i,
    input  logic        ld_last_i,
    output logic        ld_ready_o,
    output logic        boot_done_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    rom_state_e     state, state_nxt;
    logic [PW-1:0]  word_ptr;
    logic [31:0]    mem [DEPTH];
    logic           xfer;
    logic           commit;
    logic [31:0]    commit_word;
    logic [31:0]    offset;
    logic [31:0]    idx;
    logic           hit;

    assign xfer = ld_valid_i && ld_ready_o;

    rom_byte_packer u_packer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .xfer_i   (xfer),
        .byte_i   (ld_data_i),
        .last_i   (ld_last_i),
        .word_o   (commit_word),
        .commit_o (commit)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_LOAD && xfer && ld_last_i) state_nxt = ST_RUN;
    end

    always_comb begin
        ld_ready_o  = (state == ST_LOAD);
        boot_done_o = (state == ST_RUN);
    end

    // word_ptr stops moving once in RUN, so it doubles as the loaded count.
    // The top bit set means the array is full; further commits are dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            word_ptr <= '0;
            err_o    <= 1'b0;
        end else if (commit) begin
            if (word_ptr[AW]) err_o    <= 1'b1;
            else              word_ptr <= word_ptr + 1'b1;
        end
    end

    // No reset on the array: stale contents are hidden because word_ptr is 0.
    always_ff @(posedge clk_i) begin
        if (commit && !word_ptr[AW]) mem[word_ptr[AW-1:0]] <= commit_word;
    end

    always_comb begin
        offset = addr_i - BASE_ADDR;
        idx    = offset >> 2;
        hit    = (addr_i >= BASE_ADDR) && (idx < {{(32-PW){1'b0}}, word_ptr});
        if (!ce_i)                data_o = ZERO_WORD;
        else if (state != ST_RUN) data_o = NOP_INST;
        else if (!hit)            data_o = NOP_INST;
        else                      data_o = mem[idx[AW-1:0]];
    end

endmodule

// File: tb/tb_inst_rom.sv
module tb_inst_rom;
    import inst_rom_pkg::*;

    localparam int SEL_DATA = 0, SEL_RDY = 1, SEL_DONE = 2, SEL_ERR = 3;
    localparam int SEL_DATA4 = 4, SEL_RDY4 = 5, SEL_DONE4 = 6, SEL_ERR4 = 7;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clk = 0;
    logic        rst_n = 0, rst4_n = 0;
    logic        ce = 0;
    logic [31:0] addr = 0;
    logic        v = 0, l = 0, v4 = 0, l4 = 0;
    logic [7:0]  d = 0, d4 = 0;
    logic [31:0] data, data4;
    logic        rdy, done, err, rdy4, done4, err4;

    chk_t q[$];
    int   total = 0, passed = 0;

    always #5 clk = ~clk;

    inst_rom u_dut (
        .clk_i(clk), .rst_i(rst_n), .ce_i(ce), .addr_i(addr), .data_o(data),
        .ld_valid_i(v), .ld_data_i(d), .ld_last_i(l), .ld_ready_o(rdy),
        .boot_done_o(done), .err_o(err)
    );

    inst_rom #(.DEPTH(4), .BASE_ADDR(32'h0000_0100)) u_dut4 (
        .clk_i(clk), .rst_i(rst4_n), .ce_i(ce), .addr_i(addr), .data_o(data4),
        .ld_valid_i(v4), .ld_data_i(d4), .ld_last_i(l4), .ld_ready_o(rdy4),
        .boot_done_o(done4), .err_o(err4)
    );

    // Monitor: consumes every pending expectation at the falling edge.
    initial begin
        chk_t        it;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                it = q.pop_front();
                case (it.sel)
                    SEL_DATA:  act = data;
                    SEL_RDY:   act = {31'h0, rdy};
                    SEL_DONE:  act = {31'h0, done};
                    SEL_ERR:   act = {31'h0, err};
                    SEL_DATA4: act = data4;
                    SEL_RDY4:  act = {31'h0, rdy4};
                    SEL_DONE4: act = {31'h0, done4};
                    default:   act = {31'h0, err4};
                endcase
                total++;
                if (act === it.exp) passed++;
                else $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] exp, input string nm);
        chk_t it;
        it.sel = sel; it.exp = exp; it.name = nm;
        q.push_back(it);
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input int sel, input logic c, input logic [31:0] a,
                      input logic [31:0] exp, input string nm);
        ce = c; addr = a;
        expect_val(sel, exp, nm);
    endtask

    task automatic send(input int tgt, input logic [7:0] b, input logic last);
        if (tgt == 0) begin v = 1; d = b; l = last; end
        else          begin v4 = 1; d4 = b; l4 = last; end
        @(posedge clk);
        #1;
        v = 0; l = 0; v4 = 0; l4 = 0;
    endtask

    task automatic reset_main();
        rst_n = 0;
        #3;
        rst_n = 1;
        @(negedge clk);
        #1;
    endtask

    task automatic load_s1(input bit throttle);
        logic [7:0] s1 [8];
        s1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (i == 7) expect_val(SEL_DONE, 32'h0, "done_before_last");
            send(0, s1[i], i == 7);
            if (throttle) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_s1(input string tag);
        expect_val(SEL_DONE, 32'h1, {tag, "_done"});
        rd(SEL_DATA, 1, 32'h0, 32'h0000_0013, {tag, "_addr0"});
        rd(SEL_DATA, 1, 32'h4, 32'h0050_0093, {tag, "_addr4"});
        rd(SEL_DATA, 1, 32'h8, NOP_INST, {tag, "_addr8"});
    endtask

    initial begin
        // Reset state
        #2;
        expect_val(SEL_RDY, 32'h1, "rst_ready");
        expect_val(SEL_DONE, 32'h0, "rst_done");
        expect_val(SEL_ERR, 32'h0, "rst_err");
        rd(SEL_DATA, 0, 32'h0, ZERO_WORD, "rst_ce0");
        rd(SEL_DATA, 1, 32'h0, NOP_INST, "load_ce1_nop");
        rst_n = 1; rst4_n = 1;
        @(negedge clk); #1;

        // Scenario 1: two full words
        load_s1(0);
        check_s1("s1");
        expect_val(SEL_RDY, 32'h0, "s1_ready_run");
        rd(SEL_DATA, 1, 32'h6, 32'h0050_0093, "s1_addr6");
        rd(SEL_DATA, 0, 32'h4, ZERO_WORD, "run_ce0");
        send(0, 8'hFF, 1);
        rd(SEL_DATA, 1, 32'h0, 32'h0000_0013, "run_ignore_addr0");
        rd(SEL_DATA, 1, 32'h8, NOP_INST, "run_ignore_addr8");

        // Scenario 2: partial tail word
        reset_main();
        send(0, 8'hAA, 0); send(0, 8'hBB, 0); send(0, 8'hCC, 0);
        send(0, 8'hDD, 0); send(0, 8'hEE, 1);
        rd(SEL_DATA, 1, 32'h0, 32'hDDCC_BBAA, "s2_addr0");
        rd(SEL_DATA, 1, 32'h4, 32'h0000_00EE, "s2_addr4");
        rd(SEL_DATA, 1, 32'h8, NOP_INST, "s2_addr8");
        expect_val(SEL_RDY, 32'h0, "s2_ready");

        // Scenario 3: throttled valid
        reset_main();
        load_s1(1);
        check_s1("s3");

        // Scenario 6: reset mid-load, then reload
        reset_main();
        send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 0);
        rst_n = 0;
        expect_val(SEL_DONE, 32'h0, "s6_rst_done");
        expect_val(SEL_RDY, 32'h1, "s6_rst_ready");
        rst_n = 1;
        rd(SEL_DATA, 1, 32'h0, NOP_INST, "s6_load_nop");
        load_s1(0);
        check_s1("s6");

        // Scenario 4: overflow, DEPTH=4, BASE 0x100
        for (int i = 0; i < 20; i++) begin
            send(1, 8'(i + 1), i == 19);
            if (i == 15) begin
                expect_val(SEL_ERR4, 32'h0, "s4_err_at16");
                expect_val(SEL_DONE4, 32'h0, "s4_done_at16");
            end
        end
        expect_val(SEL_ERR4, 32'h1, "s4_err");
        expect_val(SEL_DONE4, 32'h1, "s4_done");
        expect_val(SEL_RDY4, 32'h0, "s4_ready");
        rd(SEL_DATA4, 1, 32'h100, 32'h0403_0201, "s4_w0");
        rd(SEL_DATA4, 1, 32'h104, 32'h0807_0605, "s4_w1");
        rd(SEL_DATA4, 1, 32'h108, 32'h0C0B_0A09, "s4_w2");
        rd(SEL_DATA4, 1, 32'h10C, 32'h100F_0E0D, "s4_w3");
        rd(SEL_DATA4, 1, 32'h0FC, NOP_INST, "s4_below_base");
        rd(SEL_DATA4, 1, 32'h110, NOP_INST, "s4_past_end");

        @(negedge clk); #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL monitor_drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
